// File: rtl/uart_pkg.sv
// uart_pkg: shared serial-link constants and receiver state encoding
package uart_pkg;
  localparam int DEF_CLKS_PER_BIT = 5208;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer plus falling-edge detector, reset to line idle
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], rx};
  always_ff @(posedge clk) sync_q <= rst ? 3'b111 : sync_d;
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling each bit at its mid-point, with false-start and framing checks
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rx_s, fall, mid, tick;
  uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_s(rx_s), .fall(fall));
  assign mid = cnt_q == CW'(HALF_BIT - 1);
  assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    shreg_d = shreg_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: if (mid) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (tick) begin
        cnt_d = '0;
        shreg_d = {rx_s, shreg_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        cnt_d = '0;
        state_d = S_IDLE;
        data_d = rx_s ? shreg_q : data_q;
        valid_d = rx_s;
        ferr_d = ~rx_s;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shreg_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shreg_q <= shreg_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
  assign data = data_q;
  assign valid = valid_q;
  assign frame_err = ferr_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a 16-cycle receiver plus two default-rate receivers
module tb_uart_rx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst_d;
  logic rx_v[3];
  logic [7:0] data_w[3];
  logic valid_w[3], ferr_w[3], busy_w[3];
  int total = 0, bad = 0;
  int vcnt[3], ecnt[3], both[3];
  logic [7:0] last[3];
  logic [7:0] cap[8];

  uart_rx #(.CLKS_PER_BIT(16)) dut (.clk(clk), .rst(rst), .rx(rx_v[0]), .data(data_w[0]),
    .valid(valid_w[0]), .frame_err(ferr_w[0]), .busy(busy_w[0]));
  uart_rx dut_a (.clk(clk), .rst(rst_d), .rx(rx_v[1]), .data(data_w[1]),
    .valid(valid_w[1]), .frame_err(ferr_w[1]), .busy(busy_w[1]));
  uart_rx dut_b (.clk(clk), .rst(rst_d), .rx(rx_v[2]), .data(data_w[2]),
    .valid(valid_w[2]), .frame_err(ferr_w[2]), .busy(busy_w[2]));

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (valid_w[i]) begin
        if (i == 0 && vcnt[0] < 8) cap[vcnt[0]] = data_w[0];
        last[i] = data_w[i];
        vcnt[i]++;
      end
      if (ferr_w[i]) ecnt[i]++;
      if (valid_w[i] && ferr_w[i]) both[i]++;
    end

  task automatic drive(input int k, input logic v, input int n);
    rx_v[k] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int k, input logic [7:0] b, input logic stop, input int p);
    drive(k, 1'b0, p);
    for (int i = 0; i < 8; i++) drive(k, b[i], p);
    drive(k, stop, p);
  endtask

  task automatic clear();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0;
      ecnt[i] = 0;
      both[i] = 0;
    end
    for (int i = 0; i < 8; i++) cap[i] = 8'hxx;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst_d = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst_d = 1'b0;
    @(negedge clk);
    total++; if (data_w[0] !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_w[0]); end
    total++; if (valid_w[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_w[0]); end
    total++; if (ferr_w[0] !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", ferr_w[0]); end
    total++; if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_w[0]); end
    total++; if (busy_w[1] !== 1'b0) begin bad++; $display("FAIL reset_busy_def got=%b exp=0", busy_w[1]); end
  endtask

  task automatic test_two_frames();
    clear();
    send(0, 8'hA5, 1'b1, 16);
    drive(0, 1'b1, 32);
    send(0, 8'h3C, 1'b1, 16);
    drive(0, 1'b1, 32);
    total++; if (vcnt[0] !== 2) begin bad++; $display("FAIL two_count got=%0d exp=2", vcnt[0]); end
    total++; if (cap[0] !== 8'hA5) begin bad++; $display("FAIL two_first got=%h exp=a5", cap[0]); end
    total++; if (cap[1] !== 8'h3C) begin bad++; $display("FAIL two_second got=%h exp=3c", cap[1]); end
    total++; if (ecnt[0] !== 0) begin bad++; $display("FAIL two_ferr got=%0d exp=0", ecnt[0]); end
  endtask

  task automatic test_false_start();
    int rise = -1, drop = -1;
    clear();
    rx_v[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) rx_v[0] = 1'b1;
      @(negedge clk);
      if (busy_w[0] && rise < 0) rise = c;
      if (!busy_w[0] && rise >= 0 && drop < 0) drop = c;
    end
    total++; if (rise < 0) begin bad++; $display("FAIL glitch_busy_rise got=%0d exp>=0", rise); end
    total++; if (drop < 0 || drop >= 12) begin bad++; $display("FAIL glitch_busy_drop got=%0d exp<12", drop); end
    total++; if (vcnt[0] !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", vcnt[0]); end
    total++; if (ecnt[0] !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", ecnt[0]); end
  endtask

  task automatic test_frame_err();
    clear();
    send(0, 8'h5A, 1'b1, 16);
    send(0, 8'h81, 1'b0, 16);
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 32);
    total++; if (vcnt[0] !== 1) begin bad++; $display("FAIL ferr_valid_count got=%0d exp=1", vcnt[0]); end
    total++; if (cap[0] !== 8'h5A) begin bad++; $display("FAIL ferr_good_byte got=%h exp=5a", cap[0]); end
    total++; if (ecnt[0] !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", ecnt[0]); end
    total++; if (data_w[0] !== 8'h5A) begin bad++; $display("FAIL ferr_data_held got=%h exp=5a", data_w[0]); end
    total++; if (both[0] !== 0) begin bad++; $display("FAIL ferr_overlap got=%0d exp=0", both[0]); end
  endtask

  task automatic test_back_to_back();
    clear();
    send(0, 8'h00, 1'b1, 16);
    send(0, 8'hFF, 1'b1, 16);
    drive(0, 1'b1, 32);
    total++; if (vcnt[0] !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", vcnt[0]); end
    total++; if (cap[0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", cap[0]); end
    total++; if (cap[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", cap[1]); end
    total++; if (ecnt[0] !== 0) begin bad++; $display("FAIL b2b_ferr got=%0d exp=0", ecnt[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'hC3;
    clear();
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, b[i], 16);
    drive(0, b[4], 8);
    rst = 1'b1;
    rx_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (data_w[0] !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", data_w[0]); end
    total++; if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy_w[0]); end
    total++; if (valid_w[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", valid_w[0]); end
    drive(0, 1'b1, 32);
    total++; if (vcnt[0] !== 0 || ecnt[0] !== 0) begin bad++; $display("FAIL mid_rst_pulse got=%0d/%0d exp=0/0", vcnt[0], ecnt[0]); end
    send(0, 8'h7E, 1'b1, 16);
    drive(0, 1'b1, 32);
    total++; if (vcnt[0] !== 1) begin bad++; $display("FAIL after_rst_count got=%0d exp=1", vcnt[0]); end
    total++; if (data_w[0] !== 8'h7E) begin bad++; $display("FAIL after_rst_data got=%h exp=7e", data_w[0]); end
  endtask

  task automatic test_tolerance();
    clear();
    fork
      send(1, 8'h55, 1'b1, 5000);
      send(2, 8'h55, 1'b1, 5400);
    join
    drive(1, 1'b1, 20);
    total++; if (vcnt[1] !== 1) begin bad++; $display("FAIL fast_count got=%0d exp=1", vcnt[1]); end
    total++; if (last[1] !== 8'h55) begin bad++; $display("FAIL fast_data got=%h exp=55", last[1]); end
    total++; if (vcnt[2] !== 1) begin bad++; $display("FAIL slow_count got=%0d exp=1", vcnt[2]); end
    total++; if (last[2] !== 8'h55) begin bad++; $display("FAIL slow_data got=%h exp=55", last[2]); end
    total++; if (ecnt[1] !== 0 || ecnt[2] !== 0) begin bad++; $display("FAIL tol_ferr got=%0d/%0d exp=0/0", ecnt[1], ecnt[2]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_v[i] = 1'b1;
      vcnt[i] = 0;
      ecnt[i] = 0;
      both[i] = 0;
      last[i] = 8'h00;
    end
    rst = 1'b1;
    rst_d = 1'b1;
    @(negedge clk);
    test_reset();
    test_two_frames();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_tolerance();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
